// File: rtl/knight_pkg.sv
// Shared definitions for the knight command path: opcodes, FSM states and
// small decode helpers used by the command responder.
package knight_pkg;

  // Command opcodes carried in cmd[15:12]
  localparam logic [3:0] OP_CAL          = 4'b0000;
  localparam logic [3:0] OP_MOVE         = 4'b0010;
  localparam logic [3:0] OP_MOVE_FANFARE = 4'b0011;

  // Line counter width; two crossings per square, up to 15 squares
  localparam int unsigned LINE_CNT_W = 5;
  localparam logic [LINE_CNT_W-1:0] LINE_CNT_MAX = '1;

  // Responder FSM states
  typedef enum logic [2:0] {
    IDLE,
    CAL,
    HDG,
    MOVE,
    RESP
  } state_t;

  // True for either flavour of move command
  function automatic logic is_move_op(input logic [3:0] op);
    return (op == OP_MOVE) || (op == OP_MOVE_FANFARE);
  endfunction

  // Heading byte to 12-bit PID setpoint; heading zero means exactly zero
  // rather than 12'h00F so that "north" is not biased by the fill nibble.
  function automatic logic [11:0] expand_heading(input logic [7:0] heading);
    return (heading == 8'h00) ? 12'h000 : {heading, 4'hF};
  endfunction

endpackage

// File: rtl/rise_edge_det.sv
// Rising-edge detector: one history flop and an AND gate. The input is
// expected to be already synchronous to clk.
module rise_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic sig,
  output logic rise
);

  logic sig_prev_reg;

  // Remember the previous sample of the input
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig_prev_reg <= 1'b0;
    end else begin
      sig_prev_reg <= sig;
    end
  end

  assign rise = sig & ~sig_prev_reg;

endmodule

// File: rtl/cmd_responder.sv
// Command responder: acknowledges a command word, then sequences gyro
// calibration or a heading-then-move manoeuvre counted in centre-line
// crossings, and finishes each command with a one-cycle response.
module cmd_responder
  import knight_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] cmd,
  input  logic        cmd_rdy,
  output logic        clr_cmd_rdy,
  output logic        send_resp,
  output logic        strt_cal,
  input  logic        cal_done,
  input  logic        heading_ok,
  input  logic        cntrIR,
  output logic [11:0] dsrd_hdg,
  output logic        moving,
  output logic        frwrd_en,
  output logic        fanfare_go,
  output logic        err_op
);

  state_t state_reg;
  state_t state_next;

  // Latched command fields; heading is kept in its expanded form
  logic [3:0]            op_reg;
  logic [3:0]            sq_reg;
  logic [11:0]           hdg_reg;
  logic [LINE_CNT_W-1:0] line_cnt_reg;

  logic                  line_rise;
  logic [LINE_CNT_W-1:0] line_target;
  logic                  load_move;
  logic                  clr_cnt;
  logic [3:0]            cmd_op;

  assign cmd_op      = cmd[15:12];
  // Two line crossings per square
  assign line_target = {sq_reg, 1'b0};
  assign dsrd_hdg    = hdg_reg;

  rise_edge_det u_ir_edge (
    .clk   (clk),
    .rst_n (rst_n),
    .sig   (cntrIR),
    .rise  (line_rise)
  );

  // State register; reset returns to IDLE even in the middle of a command
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state and output decode. Only the acknowledge-cycle outputs look at
  // the live cmd word; everything later uses the latched fields.
  always_comb begin
    state_next  = state_reg;
    clr_cmd_rdy = 1'b0;
    strt_cal    = 1'b0;
    send_resp   = 1'b0;
    moving      = 1'b0;
    frwrd_en    = 1'b0;
    fanfare_go  = 1'b0;
    err_op      = 1'b0;
    load_move   = 1'b0;
    clr_cnt     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (cmd_rdy) begin
          clr_cmd_rdy = 1'b1;
          if (cmd_op == OP_CAL) begin
            strt_cal   = 1'b1;
            state_next = CAL;
          end else if (is_move_op(cmd_op)) begin
            load_move  = 1'b1;
            state_next = HDG;
          end else begin
            state_next = RESP;
          end
        end
      end
      CAL: begin
        if (cal_done) begin
          send_resp  = 1'b1;
          state_next = IDLE;
        end
      end
      HDG: begin
        moving = 1'b1;
        if (heading_ok) begin
          // Counter is cleared on the way into MOVE, so a crossing seen in
          // this same cycle is discarded.
          clr_cnt    = 1'b1;
          state_next = (sq_reg == 4'd0) ? RESP : MOVE;
        end
      end
      MOVE: begin
        moving   = 1'b1;
        frwrd_en = 1'b1;
        if (line_cnt_reg == line_target) begin
          state_next = RESP;
        end
      end
      RESP: begin
        send_resp  = 1'b1;
        fanfare_go = (op_reg == OP_MOVE_FANFARE);
        // CAL completes without passing through RESP, so any non-move
        // opcode seen here was illegal.
        err_op     = ~is_move_op(op_reg);
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Latch opcode and square count in the acknowledge cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_reg <= 4'd0;
      sq_reg <= 4'd0;
    end else if (clr_cmd_rdy) begin
      op_reg <= cmd[15:12];
      sq_reg <= cmd[3:0];
    end
  end

  // Desired heading only changes when a move is accepted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hdg_reg <= 12'h000;
    end else if (load_move) begin
      hdg_reg <= expand_heading(cmd[11:4]);
    end
  end

  // Line crossing counter: cleared on MOVE entry, saturating increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      line_cnt_reg <= '0;
    end else if (clr_cnt) begin
      line_cnt_reg <= '0;
    end else if ((state_reg == MOVE) && line_rise && (line_cnt_reg != LINE_CNT_MAX)) begin
      line_cnt_reg <= line_cnt_reg + 1'b1;
    end
  end

endmodule

// File: tb/tb_cmd_responder.sv
// Self-checking bench for cmd_responder: a vector table for the acknowledge
// behaviour, directed multi-cycle sequences, and randomized commands checked
// against a transaction-level model of the command rules.
module tb_cmd_responder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] cmd = 16'h0000;
  logic        cmd_rdy = 1'b0;
  logic        cal_done = 1'b0;
  logic        heading_ok = 1'b0;
  logic        cntrIR = 1'b0;
  logic        clr_cmd_rdy, send_resp, strt_cal, moving, frwrd_en, fanfare_go, err_op;
  logic [11:0] dsrd_hdg;

  int vectors = 0;
  int miscompares = 0;

  // Samples taken on the falling edge of the most recent cycle
  logic        s_clr, s_resp, s_cal, s_mov, s_fwd, s_fan, s_err;
  logic [11:0] s_hdg;
  logic        resp_seen, clr_seen;
  logic [11:0] last_hdg;

  always #10 clk = ~clk;

  cmd_responder dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cmd         (cmd),
    .cmd_rdy     (cmd_rdy),
    .clr_cmd_rdy (clr_cmd_rdy),
    .send_resp   (send_resp),
    .strt_cal    (strt_cal),
    .cal_done    (cal_done),
    .heading_ok  (heading_ok),
    .cntrIR      (cntrIR),
    .dsrd_hdg    (dsrd_hdg),
    .moving      (moving),
    .frwrd_en    (frwrd_en),
    .fanfare_go  (fanfare_go),
    .err_op      (err_op)
  );

  task automatic check1(input string name, input logic act, input logic exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic check12(input string name, input logic [11:0] act, input logic [11:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // One clock cycle: sample outputs mid-cycle, then move to just after the
  // next rising edge where the caller drives new inputs.
  task automatic step();
    @(negedge clk);
    s_clr  = clr_cmd_rdy;
    s_resp = send_resp;
    s_cal  = strt_cal;
    s_mov  = moving;
    s_fwd  = frwrd_en;
    s_fan  = fanfare_go;
    s_err  = err_op;
    s_hdg  = dsrd_hdg;
    resp_seen = resp_seen | s_resp;
    clr_seen  = clr_seen | s_clr;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cmd_rdy = 1'b0;
    cal_done = 1'b0;
    heading_ok = 1'b0;
    cntrIR = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Wait (bounded) until send_resp has been sampled high
  task automatic wait_resp(input int max_cycles, output logic found);
    found = s_resp;
    for (int i = 0; i < max_cycles && !found; i++) begin
      step();
      found = s_resp;
    end
  endtask

  // One centre-line crossing followed by a low gap
  task automatic ir_pulse(input int gap);
    cntrIR = 1'b1;
    step();
    cntrIR = 1'b0;
    repeat (gap) step();
  endtask

  // Transaction-level reference: drive one command and check it against
  // the opcode rules, heading mapping and 2*squares crossing count.
  task automatic run_cmd(input logic [15:0] c);
    logic [3:0]  op;
    logic [3:0]  sq;
    logic [7:0]  h;
    logic        is_cal;
    logic        is_mv;
    logic [11:0] exp_hdg;
    logic        found;
    int          edges;
    int          n;
    op = c[15:12];
    h  = c[11:4];
    sq = c[3:0];
    is_cal = (op == 4'd0);
    is_mv  = (op == 4'd2) || (op == 4'd3);
    exp_hdg = (h == 8'd0) ? 12'h000 : 12'(h) * 12'd16 + 12'd15;
    edges = 2 * int'(sq);
    $display("txn cmd=%h op=%0d heading=%h squares=%0d", c, op, h, sq);

    cmd = c;
    cmd_rdy = 1'b1;
    step();
    check1("rnd_ack", s_clr, 1'b1);
    check1("rnd_strt_cal", s_cal, is_cal);
    check12("rnd_hdg_hold", s_hdg, last_hdg);
    cmd_rdy = 1'b0;
    cmd = 16'($urandom);

    if (is_cal) begin
      resp_seen = 1'b0;
      n = $urandom_range(0, 6);
      repeat (n) step();
      check1("rnd_cal_no_early_resp", resp_seen, 1'b0);
      cal_done = 1'b1;
      step();
      cal_done = 1'b0;
      check1("rnd_cal_resp", s_resp, 1'b1);
      check1("rnd_cal_fanfare", s_fan, 1'b0);
    end else if (!is_mv) begin
      step();
      check1("rnd_ill_resp", s_resp, 1'b1);
      check1("rnd_ill_err", s_err, 1'b1);
      check1("rnd_ill_moving", s_mov, 1'b0);
      check1("rnd_ill_fanfare", s_fan, 1'b0);
    end else begin
      last_hdg = exp_hdg;
      resp_seen = 1'b0;
      n = $urandom_range(1, 4);
      for (int k = 0; k < n; k++) begin
        cntrIR = 1'($urandom);
        step();
      end
      check12("rnd_hdg", s_hdg, exp_hdg);
      check1("rnd_hdg_moving", s_mov, 1'b1);
      check1("rnd_hdg_fwd", s_fwd, 1'b0);
      heading_ok = 1'b1;
      step();
      heading_ok = 1'b0;
      cntrIR = 1'b0;
      if (edges == 0) begin
        step();
        check1("rnd_zero_sq_resp", s_resp, 1'b1);
        check1("rnd_zero_sq_moving", s_mov, 1'b0);
        check1("rnd_zero_sq_fanfare", s_fan, op == 4'd3);
      end else begin
        step();
        check1("rnd_move_fwd", s_fwd, 1'b1);
        for (int e = 0; e < edges; e++) begin
          if (e == edges - 1) begin
            check1("rnd_no_early_resp", resp_seen, 1'b0);
            ir_pulse(0);
          end else begin
            ir_pulse($urandom_range(2, 3));
          end
        end
        wait_resp(8, found);
        check1("rnd_move_resp", found, 1'b1);
        check1("rnd_move_fanfare", s_fan, op == 4'd3);
        check1("rnd_move_err", s_err, 1'b0);
        check1("rnd_move_resp_moving", s_mov, 1'b0);
      end
    end
  endtask

  typedef struct {
    logic [15:0] cmd;
    logic        strt;
    logic        err;
    logic        mov;
    logic        resp;
    logic [11:0] hdg;
  } vec_t;

  vec_t tbl[8];

  initial begin
    logic        found;
    logic [15:0] c;
    logic [3:0]  op;
    int          r;

    resp_seen = 1'b0;
    clr_seen  = 1'b0;
    last_hdg  = 12'h000;

    // Acknowledge-cycle table: strt_cal, then next-cycle err/moving/resp/hdg
    tbl[0] = '{16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 12'h000};
    tbl[1] = '{16'h2002, 1'b0, 1'b0, 1'b1, 1'b0, 12'h000};
    tbl[2] = '{16'h3BF1, 1'b0, 1'b0, 1'b1, 1'b0, 12'hBFF};
    tbl[3] = '{16'h7000, 1'b0, 1'b1, 1'b0, 1'b1, 12'h000};
    tbl[4] = '{16'h27F0, 1'b0, 1'b0, 1'b1, 1'b0, 12'h7FF};
    tbl[5] = '{16'h1ABC, 1'b0, 1'b1, 1'b0, 1'b1, 12'h000};
    tbl[6] = '{16'hF123, 1'b0, 1'b1, 1'b0, 1'b1, 12'h000};
    tbl[7] = '{16'h2013, 1'b0, 1'b0, 1'b1, 1'b0, 12'h01F};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check1("rst_clr", clr_cmd_rdy, 1'b0);
    check1("rst_resp", send_resp, 1'b0);
    check1("rst_strt_cal", strt_cal, 1'b0);
    check1("rst_moving", moving, 1'b0);
    check1("rst_fwd", frwrd_en, 1'b0);
    check1("rst_fanfare", fanfare_go, 1'b0);
    check1("rst_err", err_op, 1'b0);
    check12("rst_hdg", dsrd_hdg, 12'h000);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      do_reset();
      $display("vec %0d cmd=%h", i, tbl[i].cmd);
      cmd = tbl[i].cmd;
      cmd_rdy = 1'b1;
      step();
      check1("tbl_clr", s_clr, 1'b1);
      check1("tbl_strt_cal", s_cal, tbl[i].strt);
      check1("tbl_ack_resp", s_resp, 1'b0);
      cmd_rdy = 1'b0;
      cmd = 16'hFFFF;
      step();
      check1("tbl_err", s_err, tbl[i].err);
      check1("tbl_moving", s_mov, tbl[i].mov);
      check1("tbl_resp", s_resp, tbl[i].resp);
      check1("tbl_fanfare", s_fan, 1'b0);
      check12("tbl_hdg", s_hdg, tbl[i].hdg);
    end

    // Calibrate: cal_done ten cycles after the acknowledge
    do_reset();
    $display("seq calibrate cmd=0000");
    cmd = 16'h0000;
    cmd_rdy = 1'b1;
    step();
    check1("cal_clr", s_clr, 1'b1);
    check1("cal_strt", s_cal, 1'b1);
    cmd_rdy = 1'b0;
    resp_seen = 1'b0;
    repeat (9) step();
    check1("cal_wait_no_resp", resp_seen, 1'b0);
    cal_done = 1'b1;
    step();
    cal_done = 1'b0;
    check1("cal_resp", s_resp, 1'b1);
    check1("cal_fanfare", s_fan, 1'b0);
    step();
    check1("cal_resp_one_cycle", s_resp, 1'b0);

    // Move 2002: four crossings required, three are not enough
    $display("seq move cmd=2002");
    cmd = 16'h2002;
    cmd_rdy = 1'b1;
    step();
    check1("mv_clr", s_clr, 1'b1);
    cmd_rdy = 1'b0;
    step();
    check12("mv_hdg_zero", s_hdg, 12'h000);
    check1("mv_hdg_fwd", s_fwd, 1'b0);
    heading_ok = 1'b1;
    step();
    heading_ok = 1'b0;
    step();
    check1("mv_fwd", s_fwd, 1'b1);
    resp_seen = 1'b0;
    repeat (3) ir_pulse(1);
    repeat (4) step();
    check1("mv_no_resp_after_3", resp_seen, 1'b0);
    ir_pulse(0);
    wait_resp(8, found);
    check1("mv_resp_after_4", found, 1'b1);
    check1("mv_fanfare", s_fan, 1'b0);

    // Move with fanfare; a crossing in the MOVE-entry cycle is discarded
    $display("seq move_fanfare cmd=3BF1");
    cmd = 16'h3BF1;
    cmd_rdy = 1'b1;
    step();
    cmd_rdy = 1'b0;
    step();
    check12("mvf_hdg", s_hdg, 12'hBFF);
    heading_ok = 1'b1;
    cntrIR = 1'b1;
    step();
    heading_ok = 1'b0;
    cntrIR = 1'b0;
    resp_seen = 1'b0;
    step();
    ir_pulse(1);
    repeat (4) step();
    check1("mvf_entry_edge_ignored", resp_seen, 1'b0);
    ir_pulse(0);
    wait_resp(8, found);
    check1("mvf_resp", found, 1'b1);
    check1("mvf_fanfare", s_fan, 1'b1);

    // Illegal opcode
    $display("seq illegal cmd=7000");
    cmd = 16'h7000;
    cmd_rdy = 1'b1;
    step();
    check1("ill_clr", s_clr, 1'b1);
    check1("ill_ack_moving", s_mov, 1'b0);
    cmd_rdy = 1'b0;
    step();
    check1("ill_resp", s_resp, 1'b1);
    check1("ill_err", s_err, 1'b1);
    check1("ill_moving", s_mov, 1'b0);
    check1("ill_fanfare", s_fan, 1'b0);
    step();
    check1("ill_resp_one_cycle", s_resp, 1'b0);

    // Zero squares: response one cycle after heading_ok
    $display("seq zero_squares cmd=27F0");
    cmd = 16'h27F0;
    cmd_rdy = 1'b1;
    step();
    cmd_rdy = 1'b0;
    step();
    heading_ok = 1'b1;
    step();
    heading_ok = 1'b0;
    check1("zs_no_resp_in_hdg", s_resp, 1'b0);
    step();
    check1("zs_resp", s_resp, 1'b1);
    check1("zs_moving", s_mov, 1'b0);

    // cmd_rdy held through MOVE, acknowledged in the first IDLE cycle
    $display("seq held_cmd_rdy cmd=2011 then 7000");
    cmd = 16'h2011;
    cmd_rdy = 1'b1;
    step();
    cmd_rdy = 1'b0;
    step();
    heading_ok = 1'b1;
    step();
    heading_ok = 1'b0;
    cmd = 16'h7000;
    cmd_rdy = 1'b1;
    clr_seen = 1'b0;
    step();
    ir_pulse(2);
    ir_pulse(0);
    wait_resp(8, found);
    check1("held_resp", found, 1'b1);
    check1("held_no_ack_outside_idle", clr_seen, 1'b0);
    step();
    check1("held_ack_in_idle", s_clr, 1'b1);
    cmd_rdy = 1'b0;
    step();
    check1("held_ill_err", s_err, 1'b1);

    // Reset in the middle of a move
    $display("seq reset_mid_move cmd=2013");
    cmd = 16'h2013;
    cmd_rdy = 1'b1;
    step();
    cmd_rdy = 1'b0;
    step();
    heading_ok = 1'b1;
    step();
    heading_ok = 1'b0;
    step();
    check1("mid_fwd_before_rst", s_fwd, 1'b1);
    ir_pulse(1);
    rst_n = 1'b0;
    #2;
    check1("mid_rst_moving", moving, 1'b0);
    check1("mid_rst_fwd", frwrd_en, 1'b0);
    check1("mid_rst_resp", send_resp, 1'b0);
    check1("mid_rst_clr", clr_cmd_rdy, 1'b0);
    check12("mid_rst_hdg", dsrd_hdg, 12'h000);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cmd = 16'h0000;
    cmd_rdy = 1'b1;
    step();
    check1("post_rst_clr", s_clr, 1'b1);
    check1("post_rst_strt", s_cal, 1'b1);
    cmd_rdy = 1'b0;
    step();
    cal_done = 1'b1;
    step();
    cal_done = 1'b0;
    check1("post_rst_resp", s_resp, 1'b1);

    // Randomized commands against the reference rules
    do_reset();
    last_hdg = 12'h000;
    for (int t = 0; t < 40; t++) begin
      r = $urandom_range(0, 9);
      if (r < 3) begin
        op = 4'd0;
      end else if (r < 6) begin
        op = 4'd2;
      end else if (r < 8) begin
        op = 4'd3;
      end else if (r == 8) begin
        op = 4'd1;
      end else begin
        op = 4'($urandom_range(4, 15));
      end
      c = {op, 8'($urandom), 4'($urandom_range(0, 15))};
      run_cmd(c);
      if ($urandom_range(0, 1) == 1) begin
        step();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
